// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: HTRANS/HSIZE/HBURST codes, the initiator
// FSM state type and a legality check for size/alignment. Reused by the
// router and later AHB blocks.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } mst_state_t;

    // Sizes above a word, or an address not aligned to the size, never
    // reach the bus.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return ~addr_lo[0];
            HSIZE_WORD: return (addr_lo == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering for a 32-bit AHB data path (combinational).
//   addr_lo     in   address bits [1:0] of the transfer
//   size        in   HSIZE of the transfer
//   wdata       in   right-justified write data
//   wdata_lanes out  write data replicated onto every lane of its size
//   rdata_lanes in   raw bus read data
//   rdata       out  selected lane, right-justified, zero-extended
module ahb_lane_steer
    import ahb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] wdata_lanes,
    input  logic [31:0] rdata_lanes,
    output logic [31:0] rdata
);

    always_comb begin
        wdata_lanes = wdata;
        rdata       = rdata_lanes;
        case (size)
            HSIZE_BYTE: begin
                wdata_lanes = {4{wdata[7:0]}};
                case (addr_lo)
                    2'd0:    rdata = {24'h0, rdata_lanes[7:0]};
                    2'd1:    rdata = {24'h0, rdata_lanes[15:8]};
                    2'd2:    rdata = {24'h0, rdata_lanes[23:16]};
                    default: rdata = {24'h0, rdata_lanes[31:24]};
                endcase
            end
            HSIZE_HALF: begin
                wdata_lanes = {2{wdata[15:0]}};
                rdata       = addr_lo[1] ? {16'h0, rdata_lanes[31:16]}
                                         : {16'h0, rdata_lanes[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: turns a valid/ready command into
// one SINGLE transfer and returns one response per command.
//   clk, reset (async, active low)
//   cmd_*  in   command request (valid/ready handshake)
//   rsp_*  out  one-cycle completion pulse with read data / error
//   h*          AHB-Lite initiator signals, all outputs registered
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// ADDR    | NONSEQ address phase, held until hready
// DATA    | data phase, hwdata driven for writes, waits for hready
// RESP    | rsp_valid pulse, back to IDLE
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic        hmastlock,
    output logic [3:0]  hprot,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic        hresp,
    input  logic [31:0] hrdata
);

    mst_state_t  state_q, state_d;
    htrans_t     htrans_q;
    logic        cmd_ready_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [31:0] wdata_q;
    logic [31:0] hwdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;
    logic [31:0] wdata_lanes;
    logic [31:0] rdata_sel;
    logic        accept;

    // cmd_ready is only ever high in IDLE, so this implies the IDLE state.
    assign accept = cmd_valid & cmd_ready_q;

    ahb_lane_steer u_steer (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .wdata       (wdata_q),
        .wdata_lanes (wdata_lanes),
        .rdata_lanes (hrdata),
        .rdata       (rdata_sel)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)
                         state_d = cmd_legal(cmd_size, cmd_addr[1:0]) ? ST_ADDR : ST_RESP;
            ST_ADDR: if (hready) state_d = ST_DATA;
            ST_DATA: if (hready) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing on the bus
    // has a combinational path from hready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_ready_q <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            rsp_valid_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            hwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_d == ST_IDLE);
            htrans_q    <= (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            rsp_valid_q <= (state_d == ST_RESP);
            if (accept) begin
                write_q     <= cmd_write;
                addr_q      <= cmd_addr;
                size_q      <= cmd_size;
                wdata_q     <= cmd_wdata;
                rsp_error_q <= ~cmd_legal(cmd_size, cmd_addr[1:0]);
                rsp_rdata_q <= '0;
            end
            // Latched command is stable during ADDR, so the steered data is
            // settled before the first DATA cycle and held throughout it.
            if (state_q == ST_ADDR)
                hwdata_q <= write_q ? wdata_lanes : '0;
            if (state_q == ST_DATA && hready) begin
                rsp_error_q <= hresp;
                rsp_rdata_q <= (!write_q && !hresp) ? rdata_sel : '0;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign haddr     = addr_q;
    assign hwrite    = write_q;
    assign hsize     = size_q;
    assign htrans    = htrans_q;
    assign hwdata    = hwdata_q;
    assign hburst    = HBURST_SINGLE;
    assign hmastlock = 1'b0;
    assign hprot     = HPROT_VAL;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: a transaction-timeline model of each command
// (request, 1+waits address cycles, 1+waits data cycles, one response)
// sets the expected outputs for every cycle; compare_cycle checks them.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    always #5 clk = ~clk;

    ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // per-cycle expectations
    logic        chk_en = 1'b0;
    logic        e_ready, e_wchk, e_rv, e_rerr, e_hwrite;
    logic [1:0]  e_htrans;
    logic [2:0]  e_hsize;
    logic [31:0] e_haddr, e_hwdata, e_rdata;

    // observations used by the literal checks
    int          acc_cyc, rsp_cyc, nonseq_total, data_w_cycles;
    logic [31:0] rsp_rd_seen, hwdata_seen;
    logic        rsp_er_seen;
    logic [2:0]  hsize_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic legal_of(input logic [31:0] a, input logic [2:0] s);
        return (s <= 3'd2) && ((a % (32'd1 << s)) == 0);
    endfunction

    function automatic logic [31:0] rep_of(input logic [31:0] w, input logic [2:0] s);
        if (s == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (s == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ext_of(input logic [31:0] d, input logic [31:0] a, input logic [2:0] s);
        logic [31:0] sh;
        sh = d >> (8 * (a % 4));
        if (s == 3'd0) return sh & 32'hFF;
        if (s == 3'd1) return sh & 32'hFFFF;
        return d;
    endfunction

    task automatic compare_cycle();
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, e_ready});
        chk("htrans", {30'b0, htrans}, {30'b0, e_htrans});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
        chk("hburst", {29'b0, hburst}, 32'd0);
        chk("hmastlock", {31'b0, hmastlock}, 32'd0);
        chk("hprot", {28'b0, hprot}, 32'd3);
        if (e_htrans == 2'b10) begin
            chk("haddr", haddr, e_haddr);
            chk("hwrite", {31'b0, hwrite}, {31'b0, e_hwrite});
            chk("hsize", {29'b0, hsize}, {29'b0, e_hsize});
        end
        if (e_wchk) chk("hwdata", hwdata, e_hwdata);
        if (e_rv) begin
            chk("rsp_rdata", rsp_rdata, e_rdata);
            chk("rsp_error", {31'b0, rsp_error}, {31'b0, e_rerr});
        end
    endtask

    task automatic observe();
        if (htrans == 2'b10) begin
            nonseq_total++;
            hsize_seen = hsize;
        end
        if (e_wchk) begin
            hwdata_seen = hwdata;
            data_w_cycles++;
        end
        if (rsp_valid) begin
            rsp_cyc     = cyc;
            rsp_rd_seen = rsp_rdata;
            rsp_er_seen = rsp_error;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_cycle();
        observe();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_idle(input logic rdy);
        e_ready = rdy; e_htrans = 2'b00; e_wchk = 1'b0; e_rv = 1'b0;
    endtask

    task automatic garbage();
        cmd_valid = 1'($urandom % 2);
        cmd_write = 1'($urandom % 2);
        cmd_addr  = $urandom;
        cmd_size  = 3'($urandom % 8);
        cmd_wdata = $urandom;
    endtask

    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input int wa, input int wd,
                          input logic err, input logic [31:0] bus_rd, input logic rst_mid);
        logic legal;
        legal = legal_of(addr, size);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
        hready = 1'($urandom % 2); hresp = 1'b0; hrdata = $urandom;
        set_idle(1'b1);
        acc_cyc = cyc;
        tick();
        if (legal) begin
            for (int i = 0; i <= wa; i++) begin
                garbage();
                hready = (i == wa); hresp = 1'b0; hrdata = $urandom;
                e_ready = 1'b0; e_htrans = 2'b10; e_haddr = addr; e_hwrite = wr;
                e_hsize = size; e_wchk = 1'b0; e_rv = 1'b0;
                tick();
            end
            for (int i = 0; i <= wd; i++) begin
                garbage();
                hready = (i == wd);
                hresp  = err && (i >= wd - 1);
                hrdata = (i == wd) ? bus_rd : $urandom;
                e_ready = 1'b0; e_htrans = 2'b00; e_wchk = wr; e_hwdata = rep_of(wdata, size);
                e_rv = 1'b0;
                if (rst_mid) begin
                    chk_en = 1'b0;
                    #2 reset = 1'b0;
                    #1;
                    chk("rst_htrans", {30'b0, htrans}, 32'd0);
                    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
                    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
                    chk("rst_haddr", haddr, 32'd0);
                    chk("rst_hwdata", hwdata, 32'd0);
                    repeat (2) @(posedge clk);
                    #1;
                    chk("rst_hold_ready", {31'b0, cmd_ready}, 32'd0);
                    cmd_valid = 1'b0; hready = 1'b1; hresp = 1'b0;
                    reset = 1'b1;
                    set_idle(1'b0);
                    chk_en = 1'b1;
                    tick();
                    chk("rst_release_ready", {31'b0, cmd_ready}, 32'd1);
                    set_idle(1'b1);
                    return;
                end
                tick();
            end
        end
        garbage();
        hready = 1'($urandom % 2); hresp = 1'b0; hrdata = $urandom;
        e_ready = 1'b0; e_htrans = 2'b00; e_wchk = 1'b0; e_rv = 1'b1;
        e_rerr  = !legal || err;
        e_rdata = (legal && !err && !wr) ? ext_of(bus_rd, addr, size) : 32'd0;
        tick();
        cmd_valid = 1'b0;
        set_idle(1'b1);
    endtask

    initial begin
        int ns0, dw0;
        logic        wr, er;
        logic [31:0] a;
        logic [2:0]  s;
        int          wa, wd, gaps;

        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        cmd_wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
        nonseq_total = 0; data_w_cycles = 0; rsp_cyc = 0;
        #2;
        chk("init_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("init_htrans", {30'b0, htrans}, 32'd0);
        chk("init_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("init_rsp_rdata", rsp_rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        set_idle(1'b0);
        chk_en = 1'b1;
        tick();
        set_idle(1'b1);
        tick();

        // word read, zero wait
        ns0 = nonseq_total;
        do_cmd(1'b0, 32'h100, 3'd2, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        chk("t1_latency", rsp_cyc - acc_cyc, 32'd3);
        chk("t1_rdata", rsp_rd_seen, 32'hDEAD_BEEF);
        chk("t1_error", {31'b0, rsp_er_seen}, 32'd0);
        chk("t1_nonseq", nonseq_total - ns0, 32'd1);

        // byte write, two data wait states
        dw0 = data_w_cycles;
        do_cmd(1'b1, 32'h103, 3'd0, 32'hA5, 0, 2, 1'b0, 32'h0, 1'b0);
        chk("t2_latency", rsp_cyc - acc_cyc, 32'd5);
        chk("t2_hwdata", hwdata_seen, 32'hA5A5_A5A5);
        chk("t2_data_cycles", data_w_cycles - dw0, 32'd3);
        chk("t2_hsize", {29'b0, hsize_seen}, 32'd0);

        // half read, upper lane
        do_cmd(1'b0, 32'h202, 3'd1, 32'h0, 0, 0, 1'b0, 32'h1234_5678, 1'b0);
        chk("t3_rdata", rsp_rd_seen, 32'h0000_1234);

        // two-cycle error response
        ns0 = nonseq_total;
        do_cmd(1'b0, 32'h300, 3'd2, 32'h0, 0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("t4_error", {31'b0, rsp_er_seen}, 32'd1);
        chk("t4_rdata", rsp_rd_seen, 32'd0);
        chk("t4_nonseq", nonseq_total - ns0, 32'd1);

        // illegal commands
        ns0 = nonseq_total;
        do_cmd(1'b0, 32'h101, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0);
        chk("t5a_latency", rsp_cyc - acc_cyc, 32'd1);
        chk("t5a_error", {31'b0, rsp_er_seen}, 32'd1);
        do_cmd(1'b1, 32'h100, 3'd3, 32'h55, 0, 0, 1'b0, 32'h0, 1'b0);
        chk("t5b_latency", rsp_cyc - acc_cyc, 32'd1);
        chk("t5_nonseq", nonseq_total - ns0, 32'd0);

        // reset during data phase, then a normal command
        do_cmd(1'b1, 32'h400, 3'd2, 32'h1111_2222, 1, 2, 1'b0, 32'h0, 1'b1);
        do_cmd(1'b0, 32'h401, 3'd0, 32'h0, 1, 1, 1'b0, 32'hCAFE_F00D, 1'b0);
        chk("t6_rdata", rsp_rd_seen, 32'h0000_00F0);
        chk("t6_latency", rsp_cyc - acc_cyc, 32'd5);

        // randomized commands against the timeline model
        for (int n = 0; n < 150; n++) begin
            gaps = int'($urandom % 3);
            for (int g = 0; g < gaps; g++) begin
                cmd_valid = 1'b0; hready = 1'($urandom % 2); hresp = 1'b0; hrdata = $urandom;
                set_idle(1'b1);
                tick();
            end
            wr = 1'($urandom % 2);
            s  = 3'($urandom % 4);
            a  = $urandom;
            if ($urandom % 4 != 0) begin
                if (s == 3'd1) a = a & ~32'd1;
                else if (s == 3'd2) a = a & ~32'd3;
            end
            wa = int'($urandom % 3);
            wd = int'($urandom % 3);
            er = (wd > 0) && ($urandom % 4 == 0);
            do_cmd(wr, a, s, $urandom, wa, wd, er, $urandom, 1'b0);
        end
        set_idle(1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

- **Function:** single-outstanding AHB-Lite initiator.
  - Converts a valid/ready command interface into AHB-Lite SINGLE transfers.
  - Returns one response per command.
- **Placement:** drives the SPI loader's `spi_h*` port on the router.
  - The router is the responder.
  - This block is the initiator end of the same bus.
- **Byte lanes:** steers data on both paths.
  - Replicates write data across byte lanes.
  - Extracts read data from the lane selected by the address.

## Interface
Parameters:
- `HPROT_VAL`, 4'b0011: constant driven on `hprot` (non-cacheable, non-bufferable, privileged, data).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_size`  in  3  HSIZE encoding: 0 = byte, 1 = half, 2 = word.
- `cmd_wdata`  in  32  write data, right-justified.
- `rsp_valid`  out  1  one-cycle pulse when the command completes.
- `rsp_rdata`  out  32  read data, right-justified, zero-extended; 0 for writes.
- `rsp_error`  out  1  qualifies `rsp_valid`; bus error or illegal command.
- `haddr`  out  32  AHB address.
- `hwrite`  out  1  AHB write.
- `hsize`  out  3  AHB size.
- `hburst`  out  3  AHB burst type.
- `hmastlock`  out  1  AHB lock.
- `hprot`  out  4  AHB protection.
- `htrans`  out  2  AHB transfer type.
- `hwdata`  out  32  AHB write data.
- `hready`  in  1  AHB ready.
- `hresp`  in  1  AHB response.
- `hrdata`  in  32  AHB read data.

## Operation
- **States:** IDLE, ADDR, DATA, RESP.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`: latch `cmd_*`.
  - Illegal command goes to RESP with error latched, and no bus transfer is issued. Illegal means either:
    - `cmd_size > 2`; or
    - misaligned: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - Legal command goes to ADDR.
- **ADDR**
  - Drive `htrans` = NONSEQ (2'b10), plus `haddr`, `hwrite`, `hsize` from the latch.
  - On `hready` = 1: go to DATA.
  - Otherwise hold every address-phase signal unchanged.
- **DATA**
  - `htrans` = IDLE (2'b00).
  - For writes, drive `hwdata` with lane-replicated data:
    - byte: `{4{wdata[7:0]}}`
    - half: `{2{wdata[15:0]}}`
    - word: as-is.
  - On `hready` = 1:
    - capture `hresp` into the error latch;
    - for reads, capture the extracted `hrdata` lane (selected by `haddr[1:0]` and size);
    - go to RESP.
  - `hresp` = 1 with `hready` = 0 (first cycle of the two-cycle error response):
    - stay in DATA;
    - `htrans` is already IDLE, so no cancellation is needed.
- **RESP**
  - `rsp_valid` = 1 for exactly one cycle; then IDLE.
  - `rsp_rdata` is 0 on error or write.
- **Constant outputs:**
  - `hburst` = 3'b000 (SINGLE), `hmastlock` = 0, `hprot` = `HPROT_VAL` at all times.
- **Throughput:** no pipelining; at most one transfer outstanding.
- **Reset low (asynchronous, any state):** go to IDLE. Values held while reset is low:
  - `htrans` = 0, `haddr` = 0, `hwrite` = 0, `hsize` = 0, `hwdata` = 0;
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0;
  - `cmd_ready` = 0 (forced); it becomes 1 on the first edge after reset deasserts.
  - A transfer in flight is abandoned. The responder is reset by the same reset.

## Timing
- **Command acceptance:** command accepted at edge T.
  - NONSEQ is visible during cycle T+1.
  - With zero wait states, DATA occupies T+2 and `rsp_valid` is high in T+3.
- **Minimum latency:**
  - 3 cycles from acceptance to `rsp_valid`.
  - 1 cycle for illegal commands (RESP directly at T+1).
- **Wait states:** each `hready` = 0 cycle in ADDR or DATA adds one cycle.
- **Next command:** `cmd_ready` returns in the cycle after `rsp_valid`, so the minimum command-to-command spacing is 4 cycles.
- **Registered outputs:** all AHB outputs are registered (flop outputs, no combinational path from `hready`).
  - `hwdata` is valid for the whole DATA state.
- **Response outputs:** `rsp_rdata`/`rsp_error` are valid only while `rsp_valid` = 1.

## Structure
- **Shared package `ahb_pkg`:**
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE codes (BYTE, HALF, WORD);
  - HBURST SINGLE;
  - state enum for this FSM.
  - The router and future AHB blocks reuse it.
- **Sub-module `ahb_lane_steer`** (combinational):
  - write replication and read extraction from (`addr[1:0]`, `size`);
  - instantiated once, shared with the router's RAM/register bridge.

## Test plan
- **Word read, zero wait:** addr 0x100, `hrdata` 0xDEADBEEF → NONSEQ in T+1, `rsp_valid` at T+3, `rsp_rdata` 0xDEADBEEF, `rsp_error` 0.
- **Byte write with waits:** addr 0x103, data 0xA5, 2 `hready`-low cycles in DATA → `hwdata` 0xA5A5A5A5 held 3 cycles, `hsize` 0, `rsp_valid` at T+5.
- **Half read, upper lane:** addr 0x202, `hrdata` 0x1234_5678 → `rsp_rdata` 0x0000_1234.
- **Error response:** DATA sees `hresp`=1/`hready`=0 then `hresp`=1/`hready`=1 → `htrans` stays IDLE, `rsp_error` 1, `rsp_rdata` 0.
- **Illegal command:** word addr 0x101 or `cmd_size` 3 → no NONSEQ issued, `rsp_valid`+`rsp_error` at T+1.
- **Reset mid-transfer:** reset low during DATA → `htrans` 0 and `rsp_valid` 0 immediately, `cmd_ready` 0 until release, then 1; next command completes normally.
